// File: rtl/seg7_hex_reader_pkg.sv
// Shared definitions for the seven-segment reader and hex encoders.
// Segment bit order is a..g from bit 6 down to bit 0, active-high.
package seg7_hex_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] SEG_HEX_0 = 7'h7E;
    localparam logic [6:0] SEG_HEX_1 = 7'h30;
    localparam logic [6:0] SEG_HEX_2 = 7'h6D;
    localparam logic [6:0] SEG_HEX_3 = 7'h79;
    localparam logic [6:0] SEG_HEX_4 = 7'h33;
    localparam logic [6:0] SEG_HEX_5 = 7'h5B;
    localparam logic [6:0] SEG_HEX_6 = 7'h5F;
    localparam logic [6:0] SEG_HEX_7 = 7'h70;
    localparam logic [6:0] SEG_HEX_8 = 7'h7F;
    localparam logic [6:0] SEG_HEX_9 = 7'h7B;
    localparam logic [6:0] SEG_HEX_A = 7'h77;
    localparam logic [6:0] SEG_HEX_B = 7'h1F;
    localparam logic [6:0] SEG_HEX_C = 7'h4E;
    localparam logic [6:0] SEG_HEX_D = 7'h3D;
    localparam logic [6:0] SEG_HEX_E = 7'h4F;
    localparam logic [6:0] SEG_HEX_F = 7'h47;

    // Entry i holds the pattern for digit i.
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_HEX_F, SEG_HEX_E, SEG_HEX_D, SEG_HEX_C,
        SEG_HEX_B, SEG_HEX_A, SEG_HEX_9, SEG_HEX_8,
        SEG_HEX_7, SEG_HEX_6, SEG_HEX_5, SEG_HEX_4,
        SEG_HEX_3, SEG_HEX_2, SEG_HEX_1, SEG_HEX_0
    };

endpackage

// File: rtl/seg7_hex_reader_decode.sv
// Combinational segment-pattern to hex-digit lookup.
// Unknown patterns report err with hex forced to zero.
module seg7_hex_decode
    import seg7_hex_reader_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] hex,
    output logic       err
);

    always_comb begin
        hex = 4'h0;
        err = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_TABLE[i]) begin
                hex = 4'(i);
                err = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_hex_reader.sv
// Debounces a seven-segment sample stream and emits one decoded
// digit per run of STABLE_CNT identical accepted samples.
module seg7_hex_reader
    import seg7_hex_reader_pkg::*;
#(
    parameter int STABLE_CNT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       seg_valid,
    input  logic [6:0] seg,
    output logic       seg_ready,
    output logic [3:0] hex,
    output logic       hex_err,
    output logic       hex_valid,
    input  logic       hex_ready
);

    localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [6:0] cand_q, cand_d;
    logic [3:0] hex_q, hex_d;
    logic       err_q, err_d;
    logic       valid_q, valid_d;

    logic       accept;
    logic [3:0] dec_hex;
    logic       dec_err;

    assign seg_ready = (state_q != ST_HOLD);
    assign accept    = seg_valid & seg_ready;

    seg7_hex_decode u_decode (
        .seg (cand_d),
        .hex (dec_hex),
        .err (dec_err)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        hex_d   = hex_q;
        err_d   = err_q;
        valid_d = valid_q;
        unique case (state_q)
            ST_IDLE, ST_COUNT: begin
                if (accept) begin
                    if (state_q == ST_COUNT && seg == cand_q) begin
                        cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 4'd1;
                    end else begin
                        cand_d = seg;
                        cnt_d  = 4'd1;
                    end
                    if (cnt_d == CNT_MAX) begin
                        state_d = ST_HOLD;
                        valid_d = 1'b1;
                        hex_d   = dec_hex;
                        err_d   = dec_err;
                    end else begin
                        state_d = ST_COUNT;
                    end
                end
            end
            ST_HOLD: begin
                // Drop the candidate so the next result needs a full new run.
                if (hex_ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    cnt_d   = 4'd0;
                    cand_d  = 7'h00;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                cnt_d   = 4'd0;
                cand_d  = 7'h00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            cand_q  <= 7'h00;
            hex_q   <= 4'h0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            hex_q   <= hex_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    assign hex       = hex_q;
    assign hex_err   = err_q;
    assign hex_valid = valid_q;

endmodule

// File: tb/tb_seg7_hex_reader.sv
// Scoreboard bench: two readers (STABLE_CNT 3 and 1) against
// a run-length reference model and a digit lookup table.
module tb_seg7_hex_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       v0, r0, v1, r1;
    logic [6:0] s0, s1;
    logic       sr0, he0, hv0, sr1, he1, hv1;
    logic [3:0] hx0, hx1;

    seg7_hex_reader #(.STABLE_CNT(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .seg_valid (v0),
        .seg       (s0),
        .seg_ready (sr0),
        .hex       (hx0),
        .hex_err   (he0),
        .hex_valid (hv0),
        .hex_ready (r0)
    );

    seg7_hex_reader #(.STABLE_CNT(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .seg_valid (v1),
        .seg       (s1),
        .seg_ready (sr1),
        .hex       (hx1),
        .hex_err   (he1),
        .hex_valid (hv1),
        .hex_ready (r1)
    );

    int checks = 0;
    int failures = 0;

    int tbl [16] = '{'h7E, 'h30, 'h6D, 'h79, 'h33, 'h5B, 'h5F, 'h70,
                     'h7F, 'h7B, 'h77, 'h1F, 'h4E, 'h3D, 'h4F, 'h47};

    function automatic logic [4:0] ref_dec(input logic [6:0] p);
        for (int i = 0; i < 16; i++)
            if (tbl[i] == int'(p)) return {1'b0, 4'(i)};
        return 5'h10;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Reference model: run length of identical accepted samples per channel.
    int         run0 = 0, run1 = 0;
    logic [6:0] cand0 = '0, cand1 = '0;
    bit         mh0 = 0, mh1 = 0;
    logic [4:0] q0[$];
    logic [4:0] q1[$];
    int         got0 = 0, got1 = 0;

    always @(posedge clk) begin
        if (rst) begin
            run0 = 0; mh0 = 0; q0.delete();
            run1 = 0; mh1 = 0; q1.delete();
        end else begin
            if (mh0) begin
                if (r0) begin
                    mh0 = 0; run0 = 0;
                    void'(q0.pop_front()); got0++;
                end
            end else if (v0) begin
                if (run0 > 0 && s0 == cand0) run0++;
                else begin cand0 = s0; run0 = 1; end
                if (run0 >= 3) begin q0.push_back(ref_dec(cand0)); mh0 = 1; end
            end
            if (mh1) begin
                if (r1) begin
                    mh1 = 0; run1 = 0;
                    void'(q1.pop_front()); got1++;
                end
            end else if (v1) begin
                cand1 = s1; run1 = 1;
                q1.push_back(ref_dec(cand1)); mh1 = 1;
            end
        end
    end

    bit mon_en = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("ch0_seg_ready", 32'(sr0), 32'(!mh0));
            chk("ch0_hex_valid", 32'(hv0), 32'(mh0));
            if (hv0) begin
                if (q0.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL ch0_result act=%0h exp=none", {he0, hx0});
                end else chk("ch0_result", 32'({he0, hx0}), 32'(q0[0]));
            end
            chk("ch1_seg_ready", 32'(sr1), 32'(!mh1));
            chk("ch1_hex_valid", 32'(hv1), 32'(mh1));
            if (hv1) begin
                if (q1.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL ch1_result act=%0h exp=none", {he1, hx1});
                end else chk("ch1_result", 32'({he1, hx1}), 32'(q1[0]));
            end
        end
    end

    task automatic drv0(input logic v, input logic [6:0] s, input logic r);
        v0 = v; s0 = s; r0 = r;
        @(posedge clk); #1;
    endtask

    task automatic drv1(input logic v, input logic [6:0] s, input logic r);
        v1 = v; s1 = s; r1 = r;
        @(posedge clk); #1;
    endtask

    int         base;
    logic [6:0] rs;

    initial begin
        v0 = 0; s0 = '0; r0 = 1;
        v1 = 0; s1 = '0; r1 = 1;
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        mon_en = 1;
        @(negedge clk);
        chk("rst_hex0", 32'({he0, hx0}), 32'h0);
        chk("rst_hex1", 32'({he1, hx1}), 32'h0);
        @(posedge clk); #1;

        repeat (3) drv0(1, 7'h6D, 1);
        chk("d2_valid", 32'(hv0), 32'h1);
        chk("d2_hex", 32'({he0, hx0}), 32'h02);
        chk("d2_ready", 32'(sr0), 32'h0);
        repeat (3) drv0(0, 7'h00, 1);

        base = got0;
        drv0(1, 7'h4E, 1); drv0(1, 7'h4E, 1);
        repeat (3) drv0(1, 7'h4F, 1);
        repeat (3) drv0(0, 7'h00, 1);
        chk("restart_count", 32'(got0 - base), 32'h1);

        repeat (3) drv0(1, 7'h7F, 0);
        repeat (5) drv0(1, 7'($urandom), 0);
        chk("hold_hex8", 32'({he0, hx0, hv0}), 32'h11);
        repeat (3) drv0(0, 7'h00, 1);

        repeat (3) drv0(1, 7'h01, 1);
        chk("err_pat", 32'({he0, hx0, hv0}), 32'h21);
        repeat (3) drv0(0, 7'h00, 1);

        base = got0;
        drv0(1, 7'h7E, 1); drv0(1, 7'h7E, 1);
        rst = 1; drv0(0, 7'h00, 1); rst = 0;
        drv0(1, 7'h7E, 1);
        repeat (3) drv0(0, 7'h00, 1);
        chk("rst_no_result", 32'(got0 - base), 32'h0);
        repeat (3) drv0(1, 7'h7E, 1);
        repeat (3) drv0(0, 7'h00, 1);
        chk("rst_new_run", 32'(got0 - base), 32'h1);

        rs = 7'h00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                if ($urandom_range(0, 1) == 0) rs = 7'(tbl[$urandom_range(0, 15)]);
                else rs = 7'($urandom);
            end
            drv0($urandom_range(0, 9) < 7, rs, $urandom_range(0, 3) != 0);
        end
        repeat (4) drv0(0, 7'h00, 1);
        chk("ch0_drained", 32'(q0.size()), 32'h0);

        base = got1;
        for (int p = 0; p < 128; p++) begin
            drv1(1, 7'(p), 1);
            drv1(0, 7'h00, 1);
        end
        repeat (2) drv1(0, 7'h00, 1);
        chk("sweep_count", 32'(got1 - base), 32'd128);
        chk("ch1_drained", 32'(q1.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_hex_reader.md
SEG7_HEX_READER -- requirements
Module: seg7_hex_reader

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 3, meaning the number of consecutive identical valid samples required before decode (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1 bit, the reset; synchronous, active-high.
REQ-004 SHALL have port seg_valid, input, 1 bit, meaning a segment sample is offered this cycle.
REQ-005 SHALL have port seg, input, 7 bits, the segment pattern; seg[6]=a, seg[5]=b, seg[4]=c, seg[3]=d, seg[2]=e, seg[1]=f, seg[0]=g; active-high.
REQ-006 SHALL have port seg_ready, output, 1 bit, meaning a sample is accepted on seg_valid&seg_ready.
REQ-007 SHALL have port hex, output, 4 bits, the decoded digit.
REQ-008 SHALL have port hex_err, output, 1 bit, meaning the stable pattern matched no hex digit.
REQ-009 SHALL have port hex_valid, output, 1 bit, meaning hex/hex_err hold a result.
REQ-010 SHALL have port hex_ready, input, 1 bit, meaning downstream consumes on hex_valid&hex_ready.

Function
REQ-011 SHALL decode the following patterns (hex: seg): 0:7E, 1:30, 2:6D, 3:79, 4:33, 5:5B, 6:5F, 7:70, 8:7F, 9:7B, A:77, B:1F, C:4E, D:3D, E:4F, F:47.
REQ-012 SHALL, for any other pattern, set hex_err=1 and hex=4'h0.
REQ-013 SHALL implement the states IDLE, COUNT and HOLD.
REQ-014 In IDLE, an accepted sample SHALL load the candidate register and set cnt=1, then go to COUNT; if STABLE_CNT=1, it SHALL go directly to HOLD.
REQ-015 In COUNT, an accepted sample equal to the candidate SHALL increment cnt; when cnt reaches STABLE_CNT, the block SHALL go to HOLD.
REQ-016 In COUNT, an accepted differing sample SHALL reload the candidate and set cnt=1 (restart, no error).
REQ-017 Cycles without seg_valid SHALL NOT affect cnt or the candidate.
REQ-018 On entry to HOLD, hex/hex_err SHALL be registered from the decode of the candidate, and hex_valid SHALL assert on the cycle after the final stable sample is accepted (latency 1).
REQ-019 seg_ready SHALL be 1 in IDLE and COUNT and 0 in HOLD.
REQ-020 In HOLD, on hex_valid&hex_ready the block SHALL clear hex_valid and return to IDLE next cycle; hex/hex_err SHALL stay stable while hex_valid=1 and hex_ready=0.
REQ-021 After a result, the block SHALL require a fresh STABLE_CNT run; the old candidate SHALL NOT be reused.
REQ-022 cnt SHALL be 4 bits and saturate at STABLE_CNT; it SHALL never wrap.

Reset
REQ-023 On rst=1 at a clock edge, the block SHALL enter IDLE with cnt=0, candidate=7'h00, hex=4'h0, hex_err=0, hex_valid=0 and seg_ready=1 on the following cycle.
REQ-024 Reset SHALL take priority over every handshake, including mid-COUNT and mid-HOLD; a pending result SHALL be discarded.

Structure
REQ-025 Shared package SHALL hold the state enum, the 16 segment-pattern constants (shared with the hex-to-segment encoders) and the a..g bit-index constants.
REQ-026 Pattern-to-hex decode SHALL be a combinational sub-module seg7_hex_decode (in: seg[6:0]; out: hex[3:0], err); the FSM, counter and output register SHALL live in seg7_hex_reader.

Verification
REQ-027 STABLE_CNT=3, seg=6D offered 3 consecutive cycles, hex_ready=1 -> hex_valid=1 one cycle after the third accept, hex=2, hex_err=0, and seg_ready=0 that cycle.
REQ-028 Samples 4E, 4E, 4F, 4F, 4F -> exactly one result, hex=E, with the restart at the third sample.
REQ-029 Pattern 7F x3 with hex_ready=0 for 5 cycles -> hex=8 and hex_valid held; seg_ready=0 throughout; samples offered meanwhile are ignored; release -> IDLE.
REQ-030 Pattern 01 x3 -> hex_valid=1, hex_err=1, hex=0.
REQ-031 rst asserted after 2 of 3 matching samples, then 1 more matching sample -> no result; a full new run of 3 is needed.
REQ-032 Sweep all 128 patterns at STABLE_CNT=1 -> the 16 table entries decode correctly and the other 112 flag hex_err.
